spi_frame_master: RTL and testbench
===================================

// Module: spi_frame_master
// PURPOSE
//  SPI initiator for the CPLD SRAM bridge. Accepts one read or write request
//  and serialises it as a 32-bit frame {cmd[1:0], 5'b0, addr[16:0], data[7:0]},
//  MSB first, SPI mode 0. For reads, returns the byte clocked back on miso.
//  Synthesizable host-side logic and the bus model for all bridge benches.
// PARAMETERS
//  CLK_DIV   4   clk cycles per sclk phase, low or high (>=1); one bit = 2*CLK_DIV
//  CS_SETUP  10  clk cycles from csn falling to the first sclk low phase (>=1)
//  CS_HOLD   20  clk cycles csn stays low after the last sclk falling edge (>=1)
//  CS_GAP    4   minimum clk cycles csn stays high between frames (>=1)
// PORTS
//  clk        in   1   system clock
//  rstn       in   1   synchronous reset, active low
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid && req_ready
//  req_write  in   1   1 = write (cmd 2'b11), 0 = read (cmd 2'b10)
//  req_addr   in   17  SRAM address
//  req_wdata  in   8   write data; ignored on reads (data field sent as 8'h00)
//  rd_valid   out  1   one-cycle pulse, read data valid
//  rd_data    out  8   byte captured from miso
//  busy       out  1   high from request accept until req_ready returns high
//  sclk       out  1   SPI clock, idles low
//  csn        out  1   chip select, active low
//  mosi       out  1   serial data out
//  miso       in   1   serial data in
// BEHAVIOUR
//  Reset (rstn=0 at a clk edge): state IDLE. csn=1, sclk=0, mosi=0, req_ready=1,
//   rd_valid=0, rd_data=8'h00, busy=0. A frame in flight is dropped at once: csn high, no rd_valid.
//  States: IDLE -> SETUP -> BIT_LO <-> BIT_HI -> HOLD -> GAP -> IDLE.
//  IDLE: req_ready=1. On accept, latch the 32-bit frame and req_write. Go to SETUP.
//   Next cycle: csn=0, busy=1, req_ready=0.
//  SETUP: csn low for CS_SETUP cycles with sclk=0. Then go to BIT_LO.
//  BIT_LO: mosi = frame[31] for the whole bit; sclk=0 for CLK_DIV cycles.
//  BIT_HI: sclk=1 for CLK_DIV cycles. miso is sampled on the clk edge where sclk rises.
//   Then shift the frame left, decrement the 6-bit bit count, and go to BIT_LO.
//   After bit 0, go to HOLD instead.
//  HOLD: sclk=0, mosi=0, csn=0 for CS_HOLD cycles. Then csn=1.
//   csn rises exactly 1+CS_SETUP+64*CLK_DIV+CS_HOLD cycles after the accept edge.
//  Read result: rd_data = the last 8 miso samples, MSB first. rd_valid pulses on the
//   same cycle csn rises, reads only. rd_data holds its value until the next read completes.
//  GAP: csn=1 for CS_GAP cycles. Then IDLE; req_ready=1 and busy=0 on the same cycle.
//  req_valid while busy is ignored; the request is not queued. Inputs are only sampled on accept.
// CONFIGURATION
//  SPI_FRAME_ABORT_EN defined: adds input `abort` (1b). abort=1 in SETUP/BIT/HOLD
//   -> next cycle sclk=0, mosi=0, csn=1, no rd_valid, enter GAP. abort ignored in IDLE/GAP.
//  Not defined: no abort port; a frame always runs to completion.
// STRUCTURE
//  spi_frame_defs.vh (shared with the bridge slave):
//   CMD_READ=2'b10, CMD_WRITE=2'b11, PAD_W=5, ADDR_W=17, DATA_W=8, FRAME_W=32,
//   state encodings.
//  Sub-module spi_clk_div: phase counter giving a one-cycle phase_end strobe every CLK_DIV cycles.
//   Reset and cleared by the FSM.
//  Top: FSM, 32-bit shift register, 8-bit miso capture, SETUP/HOLD/GAP counter.
// TESTING
//  1 Reset: rstn=0 for 3 cycles mid-frame -> csn=1, sclk=0, req_ready=1 next cycle;
//    no rd_valid.
//  2 Write addr=17'h139c6, data=8'h9c -> mosi on sclk rises = 32'hC139C69C;
//    csn low 1+10+256+20 edges after accept; no rd_valid.
//  3 Read addr=17'h00010, miso model returns 8'hA5 in the last 8 bits ->
//    mosi = 32'h80001000; rd_valid one cycle with rd_data=8'hA5, coincident with csn rise.
//  4 Back-to-back: req_valid held high for 2 requests -> csn high >= CS_GAP cycles between
//    frames; the second is accepted the cycle req_ready rises.
//  5 CLK_DIV=1: sclk toggles every clk; still exactly 32 rising edges per frame,
//    mosi stable across each rise.
//  6 SPI_FRAME_ABORT_EN: abort after bit 10 -> csn=1 the next cycle, exactly 10 sclk rises,
//    no rd_valid, req_ready after CS_GAP.

Source files
------------

// File: rtl/spi_frame_master_pkg.sv
// rtl/spi_frame_master_pkg.sv - frame constants, FSM state encoding and frame builder
// Shared by spi_frame_master, its clock divider and the bridge-side models.
// Frame layout, MSB first: {cmd[1:0], 5'b0, addr[16:0], data[7:0]}.
package spi_frame_master_pkg;

   localparam logic [1:0] CMD_READ  = 2'b10;
   localparam logic [1:0] CMD_WRITE = 2'b11;
   localparam int         PAD_W     = 5;
   localparam int         ADDR_W    = 17;
   localparam int         DATA_W    = 8;
   localparam int         FRAME_W   = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_BIT_LO = 3'd2,
      ST_BIT_HI = 3'd3,
      ST_HOLD   = 3'd4,
      ST_GAP    = 3'd5
   } state_t;

   // Reads carry a zero data byte so the target never sees stale write data.
   function automatic logic [FRAME_W-1:0] build_frame(input logic              write,
                                                      input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] wdata);
      logic [1:0]        cmd;
      logic [DATA_W-1:0] data;
      cmd  = write ? CMD_WRITE : CMD_READ;
      data = write ? wdata : '0;
      return {cmd, {PAD_W{1'b0}}, addr, data};
   endfunction

endpackage

// File: rtl/spi_frame_master_if.sv
// rtl/spi_frame_master_if.sv - request/read-return handshake and SPI pin bundle
// Signals: req_valid/req_ready/req_write/req_addr/req_wdata (request),
//          rd_valid/rd_data (read return), busy, sclk/csn/mosi/miso (SPI pins).
// master modport: the frame master's view. slave modport: host plus SPI target.
// Optional feature: SPI_FRAME_ABORT_EN adds the abort line (host -> master).
interface spi_frame_master_if;

   logic                                    req_valid;
   logic                                    req_ready;
   logic                                    req_write;
   logic [spi_frame_master_pkg::ADDR_W-1:0] req_addr;
   logic [spi_frame_master_pkg::DATA_W-1:0] req_wdata;
   logic                                    rd_valid;
   logic [spi_frame_master_pkg::DATA_W-1:0] rd_data;
   logic                                    busy;
   logic                                    sclk;
   logic                                    csn;
   logic                                    mosi;
   logic                                    miso;

`ifdef SPI_FRAME_ABORT_EN
   logic                                    abort;

   modport master (input  req_valid, req_write, req_addr, req_wdata, miso, abort,
                   output req_ready, rd_valid, rd_data, busy, sclk, csn, mosi);
   modport slave  (output req_valid, req_write, req_addr, req_wdata, miso, abort,
                   input  req_ready, rd_valid, rd_data, busy, sclk, csn, mosi);
`else
   modport master (input  req_valid, req_write, req_addr, req_wdata, miso,
                   output req_ready, rd_valid, rd_data, busy, sclk, csn, mosi);
   modport slave  (output req_valid, req_write, req_addr, req_wdata, miso,
                   input  req_ready, rd_valid, rd_data, busy, sclk, csn, mosi);
`endif

endinterface

// File: rtl/spi_frame_master_clk_div.sv
// rtl/spi_frame_master_clk_div.sv - sclk phase counter with a one-cycle phase_end strobe
// Ports: clk, rstn (sync, active low), clr_i (hold counter at zero),
//        phase_end_o (high on the last clk cycle of every CLK_DIV-cycle phase).
module spi_frame_master_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr_i,
   output logic phase_end_o
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign phase_end_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - SPI mode-0 initiator for 32-bit SRAM bridge frames
// Ports: clk, rstn (sync, active low), bus (spi_frame_master_if.master):
//        request in, one-cycle read return out, busy, sclk/csn/mosi out, miso in.
// Optional feature: SPI_FRAME_ABORT_EN adds bus.abort, which drops an active frame.
// All pin outputs are registered from the next state so they line up with the FSM.
module spi_frame_master
   import spi_frame_master_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 10,
   parameter int CS_HOLD  = 20,
   parameter int CS_GAP   = 4
) (
   input  logic               clk,
   input  logic               rstn,
   spi_frame_master_if.master bus
);

   localparam int               CNT_W    = 16;
   // SETUP runs one cycle longer than CS_SETUP: that cycle absorbs the accept latency.
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP - 1);

   state_t              state_q, state_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic                wr_q, wr_d;
   logic [5:0]          bit_q, bit_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic                rd_done, abort_hit, phase_end, in_bits, active;
   logic                csn_q, csn_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic                req_ready_q, req_ready_d, busy_q, busy_d, rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;

   assign in_bits = (state_q == ST_BIT_LO) || (state_q == ST_BIT_HI);
   assign active  = (state_q == ST_SETUP) || in_bits || (state_q == ST_HOLD);

   spi_frame_master_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clk         (clk),
      .rstn        (rstn),
      .clr_i       (!in_bits),
      .phase_end_o (phase_end)
   );

`ifdef SPI_FRAME_ABORT_EN
   assign abort_hit = bus.abort && active;
`else
   assign abort_hit = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         frame_q     <= '0;
         wr_q        <= 1'b0;
         bit_q       <= '0;
         cnt_q       <= '0;
         rx_q        <= '0;
         csn_q       <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         wr_q        <= wr_d;
         bit_q       <= bit_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         csn_q       <= csn_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      wr_d    = wr_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      rd_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               state_d = ST_SETUP;
               frame_d = build_frame(bus.req_write, bus.req_addr, bus.req_wdata);
               wr_d    = bus.req_write;
               bit_d   = 6'd31;
               cnt_d   = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_BIT_LO;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_BIT_LO: begin
            // This edge raises sclk, so it is also the miso sample point.
            if (phase_end) begin
               state_d = ST_BIT_HI;
               rx_d    = {rx_q[DATA_W-2:0], bus.miso};
            end
         end
         ST_BIT_HI: begin
            if (phase_end) begin
               frame_d = frame_q << 1;
               if (bit_q == 6'd0) begin
                  state_d = ST_HOLD;
                  cnt_d   = HOLD_LD;
               end else begin
                  state_d = ST_BIT_LO;
                  bit_d   = bit_q - 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LD;
               rd_done = !wr_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort_hit) begin
         state_d = ST_GAP;
         cnt_d   = GAP_LD;
         rd_done = 1'b0;
      end
   end

   // Output decode from the next state
   always_comb begin
      csn_d       = !((state_d == ST_SETUP) || (state_d == ST_BIT_LO) ||
                      (state_d == ST_BIT_HI) || (state_d == ST_HOLD));
      sclk_d      = (state_d == ST_BIT_HI);
      mosi_d      = ((state_d == ST_BIT_LO) || (state_d == ST_BIT_HI)) && frame_d[FRAME_W-1];
      req_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      rd_valid_d  = rd_done;
      rd_data_d   = rd_done ? rx_d : rd_data_q;
   end

   assign bus.csn       = csn_q;
   assign bus.sclk      = sclk_q;
   assign bus.mosi      = mosi_q;
   assign bus.req_ready = req_ready_q;
   assign bus.busy      = busy_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// tb/tb_spi_frame_master.sv - directed self-checking bench for spi_frame_master
// Optional feature: SPI_FRAME_ABORT_EN enables the abort scenario.
module tb_spi_frame_master;

   localparam int LIM = 5000;

   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   spi_frame_master_if bus ();
   spi_frame_master_if bus2 ();

   spi_frame_master #(.CLK_DIV(4), .CS_SETUP(10), .CS_HOLD(20), .CS_GAP(4)) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   spi_frame_master #(.CLK_DIV(1), .CS_SETUP(10), .CS_HOLD(20), .CS_GAP(4)) u_fast (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus2)
   );

   // Main-bus monitor and miso target model (target shifts on sclk falling edges)
   logic [31:0] miso_word = 32'h0000_00A5;
   logic [31:0] m_word = '0;
   logic [31:0] m_miso_sh = '0;
   logic [7:0]  m_rd_last = '0;
   int          m_rises = 0, m_stable_err = 0, m_rd_cnt = 0, m_rd_csn_err = 0;
   logic        m_sclk_p = 1'b0, m_csn_p = 1'b1, m_mosi_p = 1'b0;

   always @(negedge clk) begin
      if (bus.csn === 1'b0 && m_csn_p === 1'b1) begin
         m_rises   = 0;
         m_word    = '0;
         m_miso_sh = miso_word;
      end
      if (bus.sclk === 1'b1 && m_sclk_p === 1'b0) begin
         m_rises++;
         m_word = {m_word[30:0], bus.mosi};
         if (bus.mosi !== m_mosi_p) m_stable_err++;
      end
      if (bus.sclk === 1'b0 && m_sclk_p === 1'b1) m_miso_sh = m_miso_sh << 1;
      bus.miso = m_miso_sh[31];
      if (bus.rd_valid === 1'b1) begin
         m_rd_cnt++;
         m_rd_last = bus.rd_data;
         if (!(bus.csn === 1'b1 && m_csn_p === 1'b0)) m_rd_csn_err++;
      end
      m_sclk_p = bus.sclk;
      m_csn_p  = bus.csn;
      m_mosi_p = bus.mosi;
   end

   // Fast-instance monitor
   logic [31:0] m2_word = '0;
   int          m2_rises = 0, m2_stable_err = 0, m2_toggles = 0;
   logic        m2_sclk_p = 1'b0, m2_csn_p = 1'b1, m2_mosi_p = 1'b0;

   always @(negedge clk) begin
      if (bus2.csn === 1'b0 && m2_csn_p === 1'b1) begin
         m2_rises   = 0;
         m2_toggles = 0;
         m2_word    = '0;
      end
      if (bus2.sclk !== m2_sclk_p) m2_toggles++;
      if (bus2.sclk === 1'b1 && m2_sclk_p === 1'b0) begin
         m2_rises++;
         m2_word = {m2_word[30:0], bus2.mosi};
         if (bus2.mosi !== m2_mosi_p) m2_stable_err++;
      end
      m2_sclk_p = bus2.sclk;
      m2_csn_p  = bus2.csn;
      m2_mosi_p = bus2.mosi;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge and return #1 after its accept edge.
   task automatic req_main(input logic w, input logic [16:0] a, input logic [7:0] d, input bit hold);
      int n;
      n = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      while (bus.req_ready !== 1'b1 && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk("accept_in_time", 32'(n < LIM), 32'd1);
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 1'b0;
   endtask

   // Count clk edges from the accept edge until csn reads high.
   task automatic wait_csn_high(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (bus.csn !== 1'b1 && n < LIM);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   int n, gap;

   initial begin
      rstn          = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus2.req_valid = 1'b0;
      bus2.req_write = 1'b0;
      bus2.req_addr  = '0;
      bus2.req_wdata = '0;
      bus2.miso      = 1'b0;
`ifdef SPI_FRAME_ABORT_EN
      bus.abort  = 1'b0;
      bus2.abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_csn",       32'(bus.csn),       32'd1);
      chk("rst_sclk",      32'(bus.sclk),      32'd0);
      chk("rst_mosi",      32'(bus.mosi),      32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
      chk("rst_rd_data",   32'(bus.rd_data),   32'h00);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Write frame
      req_main(1'b1, 17'h139c6, 8'h9c, 1'b0);
      chk("wr_accept_csn",   32'(bus.csn),       32'd0);
      chk("wr_accept_busy",  32'(bus.busy),      32'd1);
      chk("wr_accept_ready", 32'(bus.req_ready), 32'd0);
      wait_csn_high(n);
      chk("wr_csn_edges", 32'(n), 32'd287);
      settle();
      chk("wr_mosi_word",  m_word,           32'hC139C69C);
      chk("wr_rises",      32'(m_rises),     32'd32);
      chk("wr_mosi_stable",32'(m_stable_err),32'd0);
      chk("wr_no_rd_valid",32'(m_rd_cnt),    32'd0);

      // Read frame
      req_main(1'b0, 17'h00010, 8'hff, 1'b0);
      wait_csn_high(n);
      chk("rd_csn_edges",  32'(n),            32'd287);
      chk("rd_valid_at_csn_rise", 32'(bus.rd_valid), 32'd1);
      chk("rd_data_out",   32'(bus.rd_data),  32'hA5);
      settle();
      chk("rd_mosi_word",  m_word,            32'h80001000);
      chk("rd_pulse_cnt",  32'(m_rd_cnt),     32'd1);
      chk("rd_pulse_csn",  32'(m_rd_csn_err), 32'd0);
      @(posedge clk);
      #1;
      chk("rd_valid_one_cycle", 32'(bus.rd_valid), 32'd0);

      // Back-to-back requests with req_valid held
      req_main(1'b1, 17'h00001, 8'h11, 1'b1);
      wait_csn_high(n);
      chk("b2b_first_edges", 32'(n), 32'd287);
      gap = 0;
      n   = 0;
      while (bus.req_ready !== 1'b1 && n < LIM) begin
         @(negedge clk);
         n++;
         if (bus.csn === 1'b1) gap++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("b2b_gap_min",        32'(gap >= 4),      32'd1);
      chk("b2b_second_accept",  32'(bus.csn),       32'd0);
      chk("b2b_second_busy",    32'(bus.busy),      32'd1);
      wait_csn_high(n);
      chk("b2b_second_edges", 32'(n), 32'd287);
      settle();
      chk("b2b_mosi_word",    m_word,           32'hC0000111);
      chk("b2b_rd_data_held", 32'(bus.rd_data), 32'hA5);
      chk("b2b_no_rd_valid",  32'(m_rd_cnt),    32'd1);

      // Reset mid-frame during a read
      req_main(1'b0, 17'h01234, 8'h00, 1'b0);
      repeat (100) @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_csn",       32'(bus.csn),       32'd1);
      chk("midrst_sclk",      32'(bus.sclk),      32'd0);
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("midrst_busy",      32'(bus.busy),      32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (400) @(negedge clk);
      #1;
      chk("midrst_no_rd_valid", 32'(m_rd_cnt),    32'd1);
      chk("midrst_rd_data",     32'(bus.rd_data), 32'h00);
      chk("midrst_csn_idle",    32'(bus.csn),     32'd1);

      // CLK_DIV=1 instance
      @(negedge clk);
      bus2.req_valid = 1'b1;
      bus2.req_write = 1'b1;
      bus2.req_addr  = 17'h0AAAA;
      bus2.req_wdata = 8'h5A;
      chk("fast_ready", 32'(bus2.req_ready), 32'd1);
      @(posedge clk);
      #1;
      bus2.req_valid = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (bus2.csn !== 1'b1 && n < LIM);
      chk("fast_csn_edges", 32'(n), 32'd95);
      settle();
      chk("fast_mosi_word",   m2_word,            32'hC0AAAA5A);
      chk("fast_rises",       32'(m2_rises),      32'd32);
      chk("fast_toggles",     32'(m2_toggles),    32'd64);
      chk("fast_mosi_stable", 32'(m2_stable_err), 32'd0);

`ifdef SPI_FRAME_ABORT_EN
      // Abort a read after its tenth bit
      req_main(1'b0, 17'h00010, 8'h00, 1'b0);
      settle();
      n = 0;
      while (!(m_rises == 10 && bus.sclk === 1'b0) && n < LIM) begin
         settle();
         n++;
      end
      chk("abort_reached_bit10", 32'(n < LIM), 32'd1);
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      chk("abort_csn",   32'(bus.csn),       32'd1);
      chk("abort_sclk",  32'(bus.sclk),      32'd0);
      chk("abort_mosi",  32'(bus.mosi),      32'd0);
      chk("abort_ready", 32'(bus.req_ready), 32'd0);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (bus.req_ready !== 1'b1 && n < LIM);
      chk("abort_gap_edges", 32'(n), 32'd4);
      settle();
      chk("abort_rises",       32'(m_rises),  32'd10);
      chk("abort_no_rd_valid", 32'(m_rd_cnt), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
